// File: rtl/wb_bram_slave.sv
// Wishbone B3 slave in front of a 2^ADDR_BITS x 32-bit block RAM.
// It supports classic cycles with programmable wait states and incrementing or wrapping bursts.
module wb_bram_slave #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic [31:2] wbs_addr_i,
    input  logic [2:0]  wbs_cti_i,
    input  logic [1:0]  wbs_bte_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_data_i,
    output logic [31:0] wbs_data_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o
);

    typedef enum logic [1:0] {IDLE, WAIT, ACK, BURST} state_t;

    localparam logic [2:0] CTI_INCR = 3'b010;
    localparam logic [2:0] CTI_END  = 3'b111;

    state_t      state, state_nx;
    logic [29:0] addr_q, addr_nx;
    logic [2:0]  cti_q, cti_nx;
    logic [1:0]  bte_q, bte_nx;
    logic        we_q, we_nx;
    logic [3:0]  cnt_q, cnt_nx;

    logic                 beat;
    logic [29:0]          beat_addr;
    logic                 beat_we;
    logic                 beat_err;
    logic                 wr_en;
    logic                 rd_en;
    logic                 ack_nx;
    logic [ADDR_BITS-1:0] beat_idx;

    logic [31:0] mem [2**ADDR_BITS];

    function automatic logic out_of_range(input logic [29:0] a);
        return (a >> ADDR_BITS) != 30'd0;
    endfunction

    // Wrapping bursts increment only the low 2/3/4 bits and keep the block base.
    function automatic logic [29:0] next_addr(input logic [29:0] a, input logic [1:0] bte);
        logic [29:0] inc;
        logic [29:0] res;
        inc = a + 30'd1;
        case (bte)
            2'b01:   res = {a[29:2], inc[1:0]};
            2'b10:   res = {a[29:3], inc[2:0]};
            2'b11:   res = {a[29:4], inc[3:0]};
            default: res = inc;
        endcase
        return res;
    endfunction

    always_comb begin
        state_nx  = state;
        addr_nx   = addr_q;
        cti_nx    = cti_q;
        bte_nx    = bte_q;
        we_nx     = we_q;
        cnt_nx    = cnt_q;
        beat      = 1'b0;
        beat_addr = addr_q;
        beat_we   = we_q;
        case (state)
            IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    addr_nx = wbs_addr_i;
                    cti_nx  = wbs_cti_i;
                    bte_nx  = wbs_bte_i;
                    we_nx   = wbs_we_i;
                    cnt_nx  = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_nx  = ACK;
                        beat      = 1'b1;
                        beat_addr = wbs_addr_i;
                        beat_we   = wbs_we_i;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!wbs_cyc_i) begin
                    state_nx = IDLE;
                    cnt_nx   = 4'd0;
                end else begin
                    cnt_nx = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_nx = ACK;
                        beat     = 1'b1;
                    end
                end
            end
            ACK, BURST: begin
                // The edge leaving ACK already serves the second burst beat, so acks stay back-to-back.
                if (!wbs_cyc_i || (state == ACK && (cti_q != CTI_INCR || wbs_err_o))) begin
                    state_nx = IDLE;
                end else if (wbs_stb_i) begin
                    beat      = 1'b1;
                    beat_addr = next_addr(addr_q, bte_q);
                    addr_nx   = beat_addr;
                    if (out_of_range(beat_addr) || wbs_cti_i == CTI_END) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = BURST;
                    end
                end else begin
                    state_nx = BURST;
                end
            end
            default: state_nx = IDLE;
        endcase
        beat_err = beat && out_of_range(beat_addr);
        wr_en    = beat && beat_we && !beat_err;
        rd_en    = beat && !beat_we && !beat_err;
        ack_nx   = beat && !beat_err;
    end

    assign beat_idx = beat_addr[ADDR_BITS-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= 30'd0;
            cti_q      <= 3'd0;
            bte_q      <= 2'd0;
            we_q       <= 1'b0;
            wbs_ack_o  <= 1'b0;
            wbs_err_o  <= 1'b0;
            wbs_data_o <= 32'd0;
        end else begin
            state      <= state_nx;
            cnt_q      <= cnt_nx;
            addr_q     <= addr_nx;
            cti_q      <= cti_nx;
            bte_q      <= bte_nx;
            we_q       <= we_nx;
            wbs_ack_o  <= ack_nx;
            wbs_err_o  <= beat_err;
            wbs_data_o <= rd_en ? mem[beat_idx] : 32'd0;
        end
    end

    // RAM has no reset; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wbs_sel_i[b]) mem[beat_idx][8*b +: 8] <= wbs_data_i[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_wb_bram_slave.sv
// Directed bench for wb_bram_slave: a Wishbone master drives transfers while a word-level
// memory model predicts ack/err/data for every cycle.
module tb_wb_bram_slave;

    localparam int AB = 10;
    localparam int WC = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [29:0] addr = '0;
    logic [2:0]  cti = '0;
    logic [1:0]  bte = '0;
    logic [3:0]  sel = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ack, err;

    wb_bram_slave #(.ADDR_BITS(AB), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .rst_n(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_addr_i(addr), .wbs_cti_i(cti),
        .wbs_bte_i(bte), .wbs_sel_i(sel), .wbs_we_i(we), .wbs_data_i(wdata),
        .wbs_data_o(rdata), .wbs_ack_o(ack), .wbs_err_o(err)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] mm [1024];
    logic        mk [1024];
    logic        exp_ack = 1'b0, exp_err = 1'b0, exp_dchk = 1'b0, chk_en = 1'b0;
    logic [31:0] exp_data = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ack", {31'd0, ack}, {31'd0, exp_ack});
            check("err", {31'd0, err}, {31'd0, exp_err});
            if (exp_dchk) check("data", rdata, exp_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        exp_ack = 1'b0;
        exp_err = 1'b0;
        exp_dchk = 1'b0;
        exp_data = '0;
    endtask

    function automatic logic [29:0] nxt(input logic [29:0] a, input logic [1:0] bt);
        logic [29:0] len;
        logic [29:0] base;
        case (bt)
            2'd1: len = 30'd4;
            2'd2: len = 30'd8;
            2'd3: len = 30'd16;
            default: len = 30'd0;
        endcase
        if (len == 30'd0) return a + 30'd1;
        base = a - (a % len);
        return base + (((a % len) + 30'd1) % len);
    endfunction

    function automatic logic [31:0] pat(input logic [29:0] a, input logic [31:0] s);
        return s ^ {2'b00, a} ^ {a[7:0], 24'h0};
    endfunction

    // Predict the outputs of the cycle that acknowledges a beat at word a.
    task automatic expect_beat(input logic w, input logic [29:0] a, output logic e);
        e = (a >= 30'd1024);
        if (e) begin
            exp_err = 1'b1; exp_dchk = 1'b1; exp_data = '0;
        end else begin
            exp_ack = 1'b1;
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (sel[b]) mm[a[9:0]][8*b +: 8] = wdata[8*b +: 8];
                if (sel == 4'hF) mk[a[9:0]] = 1'b1;
            end else if (mk[a[9:0]]) begin
                exp_dchk = 1'b1; exp_data = mm[a[9:0]];
            end
        end
    endtask

    task automatic classic(input logic w, input logic [29:0] a, input logic [3:0] s,
                           input logic [31:0] d, input int extra);
        logic e;
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; sel = s; wdata = d; cti = 3'b000; bte = 2'b00;
        repeat (extra + WC) step();
        step();
        expect_beat(w, a, e);
    endtask

    task automatic idle(input int n);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        repeat (n) step();
    endtask

    task automatic burst(input logic w, input logic [29:0] start, input logic [1:0] bt, input int n,
                         input int stall_at, input int stall_len, input int abort_at, input int rst_at,
                         input logic [31:0] salt);
        logic [29:0] a;
        logic e;
        a = start; e = 1'b0;
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; bte = bt; sel = 4'hF;
        cti = (n == 1) ? 3'b111 : 3'b010; wdata = pat(a, salt);
        repeat (WC) step();
        step();
        expect_beat(w, a, e);
        for (int i = 1; i < n && !e; i++) begin
            if (i == abort_at) begin
                cyc = 1'b0; stb = 1'b0;
                return;
            end
            if (i == rst_at) begin
                @(negedge clk);
                #1;
                exp_ack = 1'b0; exp_err = 1'b0; exp_dchk = 1'b0;
                rst_n = 1'b0; cyc = 1'b0; stb = 1'b0;
                #1;
                check("rst_ack", {31'd0, ack}, 32'd0);
                check("rst_err", {31'd0, err}, 32'd0);
                check("rst_data", rdata, 32'd0);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                return;
            end
            if (i == stall_at) begin
                stb = 1'b0;
                repeat (stall_len) step();
            end
            a = nxt(a, bt);
            stb = 1'b1; addr = a; cti = (i == n - 1) ? 3'b111 : 3'b010; wdata = pat(a, salt);
            step();
            expect_beat(w, a, e);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin mm[i] = '0; mk[i] = 1'b0; end
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_ack", {31'd0, ack}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_data", rdata, 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        idle(1);

        // Literal pins on the address model
        check("nxt_wrap4_a", {2'b0, nxt(30'h0E, 2'd1)}, 32'h0F);
        check("nxt_wrap4_b", {2'b0, nxt(30'h0F, 2'd1)}, 32'h0C);
        check("nxt_wrap4_c", {2'b0, nxt(30'h0C, 2'd1)}, 32'h0D);
        check("nxt_wrap8",   {2'b0, nxt(30'h0F, 2'd2)}, 32'h08);
        check("nxt_wrap16",  {2'b0, nxt(30'h1F, 2'd3)}, 32'h10);
        check("nxt_linear",  {2'b0, nxt(30'h3FF, 2'd0)}, 32'h400);

        // Classic write/read and byte-lane write
        classic(1'b1, 30'h10, 4'hF, 32'hDEADBEEF, 0); idle(1);
        classic(1'b0, 30'h10, 4'hF, 32'h0, 0);
        check("rd_full_word", rdata, 32'hDEADBEEF);
        check("rd_full_ack", {31'd0, ack}, 32'd1);
        idle(1);
        classic(1'b1, 30'h10, 4'b0010, 32'h0000AB00, 0); idle(1);
        check("model_byte", mm[10'h10], 32'hDEADABEF);
        classic(1'b0, 30'h10, 4'hF, 32'h0, 0);
        check("rd_byte_merge", rdata, 32'hDEADABEF);
        idle(1);

        // Back-to-back classic: second request is accepted one edge late
        classic(1'b1, 30'h11, 4'hF, 32'h12345678, 0);
        classic(1'b0, 30'h11, 4'hF, 32'h0, 1);
        idle(1);

        // Wrapping bursts
        burst(1'b1, 30'h0C, 2'd0, 4, -1, 0, -1, -1, 32'h11000000); idle(1);
        burst(1'b0, 30'h0E, 2'd1, 4, -1, 0, -1, -1, 32'h0); idle(1);
        burst(1'b1, 30'h08, 2'd0, 8, -1, 0, -1, -1, 32'h22000000); idle(1);
        burst(1'b0, 30'h0B, 2'd2, 8, -1, 0, -1, -1, 32'h0); idle(1);
        burst(1'b1, 30'h1D, 2'd3, 4, -1, 0, -1, -1, 32'h33000000); idle(1);
        burst(1'b0, 30'h1D, 2'd3, 4, -1, 0, -1, -1, 32'h0); idle(1);

        // Out-of-range accesses
        classic(1'b0, 30'h400, 4'hF, 32'h0, 0);
        check("oor_err", {31'd0, err}, 32'd1);
        check("oor_ack", {31'd0, ack}, 32'd0);
        check("oor_data", rdata, 32'd0);
        idle(1);
        classic(1'b1, 30'h001, 4'hF, 32'hC0FFEE01, 0); idle(1);
        classic(1'b1, 30'h401, 4'hF, 32'hBAD0BAD0, 0); idle(1);
        classic(1'b0, 30'h001, 4'hF, 32'h0, 0);
        check("oor_no_alias", rdata, 32'hC0FFEE01);
        idle(1);

        // Linear burst running off the end of the RAM
        burst(1'b1, 30'h3FE, 2'd0, 2, -1, 0, -1, -1, 32'h44000000); idle(1);
        burst(1'b0, 30'h3FE, 2'd0, 4, -1, 0, -1, -1, 32'h0); idle(1);

        // Master stall mid-burst
        burst(1'b1, 30'h20, 2'd0, 6, -1, 0, -1, -1, 32'h55000000); idle(1);
        burst(1'b0, 30'h20, 2'd0, 6, 2, 2, -1, -1, 32'h0); idle(1);

        // Abort mid-burst: beats 0..2 land, 3..4 keep old data
        burst(1'b1, 30'h30, 2'd0, 5, -1, 0, -1, -1, 32'h66000000); idle(1);
        burst(1'b1, 30'h30, 2'd0, 5, -1, 0, 3, -1, 32'h77000000); idle(2);
        burst(1'b0, 30'h30, 2'd0, 5, -1, 0, -1, -1, 32'h0); idle(1);

        // Abort during the wait state
        classic(1'b1, 30'h50, 4'hF, 32'h11112222, 0); idle(1);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 30'h50; sel = 4'hF; wdata = 32'h99998888; cti = 3'b000;
        step();
        idle(3);
        classic(1'b0, 30'h50, 4'hF, 32'h0, 0);
        check("wait_abort_nowrite", rdata, 32'h11112222);
        idle(1);

        // Reset mid write burst: beats 0..1 land, 2..4 keep old data
        burst(1'b1, 30'h40, 2'd0, 5, -1, 0, -1, -1, 32'h88000000); idle(1);
        burst(1'b1, 30'h40, 2'd0, 5, -1, 0, -1, 2, 32'h99000000); idle(2);
        burst(1'b0, 30'h40, 2'd0, 5, -1, 0, -1, -1, 32'h0); idle(1);
        check("rst_kept_beat", mm[10'h41], pat(30'h41, 32'h99000000));
        check("rst_untouched", mm[10'h42], pat(30'h42, 32'h88000000));

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
